alu_seq: RTL and testbench

- Parametrised, sequential successor to the team's 8-bit combinational ALU.
- Keeps the same 16-opcode set, generalised to WIDTH bits.
- Registers all results and carries iterative multi-cycle multiply/divide.
- Valid/ready handshakes on the operand and result sides, so it drops into pipelined datapaths with backpressure.
- One operation in flight at a time.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_seq_muldiv.sv | 101 ++++++++++
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, flag bit
// positions and the controller state type.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROTL = 4'h6;
  localparam logic [3:0] OP_ROTR = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [3:0] OP_SWAP = 4'hF;

  localparam int unsigned FLG_Z  = 0;
  localparam int unsigned FLG_C  = 1;
  localparam int unsigned FLG_N  = 2;
  localparam int unsigned FLG_V  = 3;
  localparam int unsigned FLG_DZ = 4;
  localparam int unsigned FLG_EQ = 5;
  localparam int unsigned FLG_GT = 6;
  localparam int unsigned FLG_LT = 7;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESULT
  } state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (LSB-first shift-add) and restoring divide,
// one step per cycle, WIDTH steps per operation.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hi_nonzero
);

  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] d_q, d_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] step_hi, step_lo;

  // hi/lo form the {product} pair for mul and {remainder, quotient} for div;
  // d holds the multiplicand or divisor.
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, d_q};
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    step_hi = hi_q;
    step_lo = lo_q;
    if (div_q) begin
      if (rem_sh >= {1'b0, d_q}) begin
        step_hi = WIDTH'(rem_sh - {1'b0, d_q});
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = {1'b0, hi_q[WIDTH-1:1]};
      step_lo = {hi_q[0], lo_q[WIDTH-1:1]};
    end
  end

  // The final step's result is presented combinationally so the caller can
  // register it on the same edge that completes the last iteration.
  assign done       = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign result     = step_lo;
  assign hi_nonzero = |step_hi;

  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    d_d    = d_q;
    if (start) begin
      busy_d = 1'b1;
      div_d  = op;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = op ? a : b;
      d_d    = op ? b : a;
    end else if (busy_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      d_q    <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      d_q    <= d_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU with valid/ready handshakes, registered results
// and flags, and an iterative multiply/divide unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [7:0]       flags
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [7:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic             is_div_q, is_div_d;

  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] sc_res;
  logic [7:0]       sc_flg;
  logic             accept, is_iter, md_start, md_done, md_hi_nz;
  logic [WIDTH-1:0] md_result;

  assign in_ready  = (state_q == IDLE) && !out_valid_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign flags     = flags_q;

  assign accept   = in_valid && in_ready;
  assign is_iter  = (opcode == OP_MUL) || ((opcode == OP_DIV) && (b != '0));
  assign md_start = accept && is_iter;

  alu_seq_muldiv #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
    .op        (opcode == OP_DIV),
    .a         (a),
    .b         (b),
    .done      (md_done),
    .result    (md_result),
    .hi_nonzero(md_hi_nz)
  );

  // Single-cycle datapath; OP_DIV only lands here when dividing by zero.
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} - {1'b0, b};
    sc_res   = '0;
    sc_flg   = '0;
    case (opcode)
      OP_ADD: begin
        sc_res        = add_full[WIDTH-1:0];
        sc_flg[FLG_C] = add_full[WIDTH];
        sc_flg[FLG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res        = sub_full[WIDTH-1:0];
        sc_flg[FLG_C] = sub_full[WIDTH];
        sc_flg[FLG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DIV: begin
        sc_res         = '1;
        sc_flg[FLG_DZ] = 1'b1;
      end
      OP_SHL: begin
        sc_res        = {a[WIDTH-2:0], 1'b0};
        sc_flg[FLG_C] = a[WIDTH-1];
      end
      OP_SHR: begin
        sc_res        = {1'b0, a[WIDTH-1:1]};
        sc_flg[FLG_C] = a[0];
      end
      OP_ROTL: begin
        sc_res        = {a[WIDTH-2:0], a[WIDTH-1]};
        sc_flg[FLG_C] = a[WIDTH-1];
      end
      OP_ROTR: begin
        sc_res        = {a[0], a[WIDTH-1:1]};
        sc_flg[FLG_C] = a[0];
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_NAND: sc_res = ~(a & b);
      OP_NOT:  sc_res = ~a;
      OP_CMP: begin
        sc_flg[FLG_EQ] = (a == b);
        sc_flg[FLG_GT] = (a > b);
        sc_flg[FLG_LT] = (a < b);
      end
      OP_SWAP: sc_res = {a[WIDTH/2-1:0], a[WIDTH-1:WIDTH/2]};
      default: sc_res = '0;
    endcase
    sc_flg[FLG_Z] = (sc_res == '0);
    sc_flg[FLG_N] = sc_res[WIDTH-1];
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    is_div_d    = is_div_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_iter) begin
            state_d  = BUSY;
            is_div_d = (opcode == OP_DIV);
          end else begin
            state_d     = RESULT;
            out_d       = sc_res;
            flags_d     = sc_flg;
            out_valid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          state_d        = RESULT;
          out_valid_d    = 1'b1;
          out_d          = md_result;
          flags_d        = '0;
          flags_d[FLG_Z] = (md_result == '0);
          flags_d[FLG_N] = md_result[WIDTH-1];
          flags_d[FLG_V] = md_hi_nz && !is_div_q;
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      is_div_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      is_div_q    <= is_div_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8 and WIDTH=16 against an
// arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8;
  logic [7:0] a8, b8, o8, f8;
  logic [3:0] op8;

  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16, o16;
  logic [7:0]  f16;
  logic [3:0]  op16;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .opcode(op8), .out_valid(ov8), .out_ready(or8), .out(o8), .flags(f8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .opcode(op16), .out_valid(ov16), .out_ready(or16), .out(o16), .flags(f16)
  );

  // Returns {flags, result} for a w-bit ALU, computed with plain arithmetic.
  function automatic logic [23:0] model(input int unsigned w, input longint unsigned ai,
                                        input longint unsigned bi, input logic [3:0] op);
    longint unsigned mask, msb, full, r, x, y;
    logic c, v, dz, eq, gt, lt;
    mask = (64'd1 << w) - 1;
    msb  = 64'd1 << (w - 1);
    x = ai & mask;
    y = bi & mask;
    r = 0; c = 0; v = 0; dz = 0; eq = 0; gt = 0; lt = 0;
    case (op)
      OP_ADD:  begin full = x + y; r = full & mask; c = (full >> w) != 0;
                     v = ((x ^ r) & (y ^ r) & msb) != 0; end
      OP_SUB:  begin r = (x - y) & mask; c = x < y; v = ((x ^ y) & (x ^ r) & msb) != 0; end
      OP_MUL:  begin full = x * y; r = full & mask; v = (full >> w) != 0; end
      OP_DIV:  begin if (y == 0) begin r = mask; dz = 1; end else r = x / y; end
      OP_SHL:  begin r = (x << 1) & mask; c = (x & msb) != 0; end
      OP_SHR:  begin r = x >> 1; c = x[0]; end
      OP_ROTL: begin r = ((x << 1) | (x >> (w - 1))) & mask; c = (x & msb) != 0; end
      OP_ROTR: begin r = (x >> 1) | ((x & 1) << (w - 1)); c = x[0]; end
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y) & mask;
      OP_NAND: r = ~(x & y) & mask;
      OP_NOT:  r = ~x & mask;
      OP_CMP:  begin r = 0; eq = x == y; gt = x > y; lt = x < y; end
      default: r = ((x & ((64'd1 << (w / 2)) - 1)) << (w / 2)) | (x >> (w / 2));
    endcase
    return {lt, gt, eq, dz, v, (r & msb) != 0, c, r == 0, r[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] get_out(input bit wide);
    return wide ? o16 : {8'h00, o8};
  endfunction
  function automatic logic [7:0] get_flags(input bit wide);
    return wide ? f16 : f8;
  endfunction
  function automatic logic get_ov(input bit wide);
    return wide ? ov16 : ov8;
  endfunction
  function automatic logic get_ir(input bit wide);
    return wide ? ir16 : ir8;
  endfunction

  task automatic drive(input bit wide, input logic iv, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] op);
    if (wide) begin
      iv16 = iv; a16 = a; b16 = b; op16 = op;
    end else begin
      iv8 = iv; a8 = a[7:0]; b8 = b[7:0]; op8 = op;
    end
  endtask

  task automatic set_ready(input bit wide, input logic r);
    if (wide) or16 = r; else or8 = r;
  endtask

  // One transaction: accept, scramble the inputs, wait for the result with a
  // cycle budget, optionally stall the consumer for `hold` cycles, then drain.
  task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input int hold, input string tag);
    int unsigned w;
    logic [23:0] exp;
    int lat, exp_lat;
    w = wide ? 16 : 8;
    exp = model(w, a, b, op);
    exp_lat = (op == OP_MUL || (op == OP_DIV && (b & ((17'd1 << w) - 1)) != 0)) ? w + 1 : 1;
    set_ready(wide, hold == 0);
    @(negedge clk);
    check({tag, ".in_ready"}, get_ir(wide), 1);
    drive(wide, 1'b1, a, b, op);
    @(negedge clk);
    drive(wide, 1'b0, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
    lat = 1;
    while (!get_ov(wide) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".out"}, get_out(wide), exp[15:0]);
    check({tag, ".flags"}, get_flags(wide), exp[23:16]);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        check({tag, ".hold_out"}, get_out(wide), exp[15:0]);
        check({tag, ".hold_flags"}, get_flags(wide), exp[23:16]);
        check({tag, ".hold_state"}, {get_ov(wide), get_ir(wide)}, 2'b10);
        drive(wide, 1'b1, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
        @(negedge clk);
      end
      drive(wide, 1'b0, '0, '0, '0);
      set_ready(wide, 1'b1);
    end
    @(negedge clk);
    check({tag, ".drained"}, {get_ov(wide), get_ir(wide)}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    logic [3:0] rop;
    logic [15:0] ra, rb;
    rst = 1'b1;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    or8 = 1'b1;
    or16 = 1'b1;
    repeat (2) @(negedge clk);
    check("reset.out_valid", ov8, 0);
    check("reset.out", o8, 0);
    check("reset.flags", f8, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset.in_ready", ir8, 1);

    run_op(0, 16'hFF, 16'h01, OP_ADD, 0, "add_ff_01");
    run_op(0, 16'h10, 16'h10, OP_MUL, 0, "mul_10_10");
    run_op(0, 16'h0C, 16'h0B, OP_MUL, 0, "mul_0c_0b");
    run_op(0, 16'd200, 16'd7, OP_DIV, 0, "div_200_7");
    run_op(0, 16'h55, 16'h00, OP_DIV, 0, "div_by_zero");
    run_op(0, 16'h05, 16'h09, OP_CMP, 0, "cmp_lt");
    run_op(0, 16'h09, 16'h09, OP_CMP, 0, "cmp_eq");
    run_op(0, 16'h05, 16'h09, OP_SUB, 0, "sub_borrow");
    run_op(0, 16'h7F, 16'h01, OP_ADD, 0, "add_overflow");
    run_op(0, 16'h3C, 16'hA5, OP_XOR, 5, "backpressure");

    // Reset four cycles into a divide must discard the operation.
    @(negedge clk);
    drive(0, 1'b1, 16'd200, 16'd7, OP_DIV);
    @(negedge clk);
    drive(0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy.out_valid", ov8, 0);
    check("rst_busy.out", o8, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy.in_ready", ir8, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | ov8;
    end
    check("rst_busy.no_stale", seen, 0);

    run_op(1, 16'h1234, 16'h0000, OP_SWAP, 0, "swap16");
    run_op(1, 16'h0001, 16'h0000, OP_ROTR, 0, "rotr16");
    run_op(1, 16'hFFFF, 16'hFFFF, OP_MUL, 0, "mul16_max");
    run_op(1, 16'hFFFF, 16'h0003, OP_DIV, 0, "div16");

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run_op(0, ra, rb, rop, $urandom_range(0, 2), "rand8");
    end
    for (int i = 0; i < 16; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run_op(1, ra, rb, rop, $urandom_range(0, 2), "rand16");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
